// File: rtl/clk_prog_pkg.sv
// Shared constants and FSM state encoding for the clock-synthesizer programming arbiter.
package clk_prog_pkg;
    localparam int CLK_WORD_W      = 32;
    localparam int ADDR_LSB_W      = 4;
    localparam int HOLD_CYCLES_DEF = 450000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        HOLD  = 2'd2
    } state_e;
endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin selector: priority starts at ptr+1 and ascends with wrap.
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    output logic [N-1:0]         gnt,
    output logic [$clog2(N)-1:0] gnt_idx
);
    localparam int IW = $clog2(N);

    always_comb begin
        int   j;
        logic found;
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        j       = 0;
        for (int i = 1; i <= N; i++) begin
            j = (int'(ptr) + i) % N;
            if (!found && req[j]) begin
                found      = 1'b1;
                gnt[j]     = 1'b1;
                gnt_idx    = IW'(j);
            end
        end
    end
endmodule

// File: rtl/clk_prog_arbiter.sv
// Shares the MICROWIRE programming engine between N_REQ requesters, spacing writes by HOLD_CYCLES
// and rejecting words whose address nibble would not be seen as a new write.
module clk_prog_arbiter
    import clk_prog_pkg::*;
#(
    parameter int N_REQ       = 4,
    parameter int HOLD_CYCLES = HOLD_CYCLES_DEF,
    parameter int CNT_W       = 20
) (
    input  logic                        CLK,
    input  logic                        rst,
    input  logic [N_REQ-1:0]            req,
    input  logic [CLK_WORD_W*N_REQ-1:0] req_word,
    output logic [N_REQ-1:0]            ack,
    output logic [N_REQ-1:0]            err,
    input  logic                        prog_done,
    output logic [CLK_WORD_W-1:0]       clk_word,
    output logic                        busy
);
    localparam int IW = $clog2(N_REQ);

    state_e                              state;
    logic [CNT_W-1:0]                    cnt;
    logic [IW-1:0]                       ptr;
    logic [IW-1:0]                       win_idx;
    logic [N_REQ-1:0]                    win_oh;
    logic [N_REQ-1:0]                    gnt;
    logic [IW-1:0]                       gnt_idx;
    logic [N_REQ-1:0][CLK_WORD_W-1:0]    words;
    logic [CLK_WORD_W-1:0]               clk_word_inv;
    logic                                collide;

    assign words   = req_word;
    assign collide = words[win_idx][ADDR_LSB_W-1:0] == clk_word[ADDR_LSB_W-1:0];

    rr_arbiter #(.N(N_REQ)) u_rr (
        .req     (req),
        .ptr     (ptr),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    always_ff @(posedge CLK) begin
        if (rst) begin
            state   <= IDLE;
            ack     <= '0;
            err     <= '0;
            busy    <= 1'b0;
            cnt     <= '0;
            ptr     <= IW'(N_REQ - 1);
            win_idx <= '0;
            win_oh  <= '0;
        end else begin
            ack <= '0;
            err <= '0;
            case (state)
                IDLE: begin
                    if (prog_done && |req) begin
                        state   <= GRANT;
                        busy    <= 1'b1;
                        win_idx <= gnt_idx;
                        win_oh  <= gnt;
                    end
                end
                GRANT: begin
                    ptr <= win_idx;
                    if (collide) begin
                        err   <= win_oh;
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        ack   <= win_oh;
                        cnt   <= CNT_W'(HOLD_CYCLES - 1);
                        state <= HOLD;
                    end
                end
                HOLD: begin
                    if (cnt == '0) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // Held inverted and never reset: the all-zero power-up state of the flops presents
    // all ones to the engine, and a reset cannot fake an address-nibble change.
    always_ff @(posedge CLK) begin
        if (!rst && state == GRANT && !collide)
            clk_word_inv <= ~words[win_idx];
    end

    assign clk_word = ~clk_word_inv;
endmodule

// File: tb/tb_clk_prog_arbiter.sv
// Scoreboard bench: expected pulses (kind, requester, word, cycle) are queued when requests are driven.
module tb_clk_prog_arbiter;
    localparam int N    = 4;
    localparam int HOLD = 16;

    logic             CLK = 1'b0;
    logic             rst;
    logic [N-1:0]     req;
    logic [N-1:0][31:0] words;
    logic [N-1:0]     ack;
    logic [N-1:0]     err;
    logic             prog_done;
    logic [31:0]      clk_word;
    logic             busy;

    int cyc = 0;
    int n_tot = 0;
    int n_bad = 0;

    typedef struct {
        bit          is_err;
        int          idx;
        logic [31:0] word;
        int          at;
    } exp_t;
    exp_t sb[$];

    clk_prog_arbiter #(.N_REQ(N), .HOLD_CYCLES(HOLD), .CNT_W(5)) dut (
        .CLK       (CLK),
        .rst       (rst),
        .req       (req),
        .req_word  (words),
        .ack       (ack),
        .err       (err),
        .prog_done (prog_done),
        .clk_word  (clk_word),
        .busy      (busy)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tot++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h (cyc %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic push(input bit e, input int idx, input logic [31:0] w, input int at);
        exp_t x;
        x.is_err = e; x.idx = idx; x.word = w; x.at = at;
        sb.push_back(x);
    endtask

    // Called at a negedge: compare any pulse with the scoreboard head and let the requester drop.
    task automatic sample();
        logic [N-1:0] p;
        exp_t e;
        p = ack | err;
        if (p != '0) begin
            if (sb.size() == 0) begin
                chk("spurious", 32'(p), 32'd0);
            end else begin
                e = sb.pop_front();
                chk("kind",  32'(err != '0), 32'(e.is_err));
                chk("pulse", 32'(e.is_err ? err : ack), 32'(4'b0001 << e.idx));
                chk("other", 32'(e.is_err ? ack : err), 32'd0);
                chk("word",  clk_word, e.word);
                chk("cycle", 32'(cyc), 32'(e.at));
            end
            req = req & ~p;
        end
    endtask

    task automatic run(input int budget);
        int n;
        n = 0;
        while (sb.size() > 0 && n < budget) begin
            @(negedge CLK);
            n++;
            sample();
        end
        if (sb.size() > 0) begin
            chk("timeout", 32'(sb.size()), 32'd0);
            sb.delete();
        end
    endtask

    task automatic quiet(input int n);
        repeat (n) begin
            @(negedge CLK);
            sample();
        end
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 100; i++) begin
            @(negedge CLK);
            sample();
            if (!busy) break;
        end
        chk("idle", 32'(busy), 32'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(negedge CLK);
        rst = 1'b0;
    endtask

    initial begin
        int c0;
        rst = 1'b1; req = '0; words = '0; prog_done = 1'b0;
        repeat (3) @(negedge CLK);
        rst = 1'b0;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ack",  32'(ack),  32'd0);
        chk("rst_err",  32'(err),  32'd0);
        chk("poweron_word", clk_word, 32'hFFFF_FFFF);

        // Power-on: nibble F collides with the all-ones idle word.
        prog_done = 1'b1;
        words[1] = 32'h1234_567F; req = 4'b0010; c0 = cyc;
        push(1'b1, 1, 32'hFFFF_FFFF, c0 + 2);
        run(20);
        chk("err_busy", 32'(busy), 32'd0);
        quiet(3);
        do_reset();

        // Gating on prog_done.
        prog_done = 1'b0;
        words[0] = 32'h0000_00A5; req = 4'b0001;
        quiet(1000);
        chk("gate_busy", 32'(busy), 32'd0);
        chk("gate_req",  32'(req),  32'h1);
        prog_done = 1'b1; c0 = cyc;
        push(1'b0, 0, 32'h0000_00A5, c0 + 2);
        run(20);
        chk("hold_busy", 32'(busy), 32'd1);
        do_reset();
        chk("rst_keep_word", clk_word, 32'h0000_00A5);

        // Fairness from reset priority.
        words[0] = 32'h1000_0001; words[1] = 32'h2000_0002;
        words[2] = 32'h3000_0003; words[3] = 32'h4000_0004;
        req = 4'b1111; c0 = cyc;
        for (int k = 0; k < 4; k++)
            push(1'b0, k, words[k], c0 + 2 + k * (HOLD + 2));
        run(200);
        wait_idle();

        // Wrap-around: last winner 3, so 0 goes before 3.
        words[0] = 32'h5000_0005; words[3] = 32'h6000_0006;
        req = 4'b1001; c0 = cyc;
        push(1'b0, 0, 32'h5000_0005, c0 + 2);
        push(1'b0, 3, 32'h6000_0006, c0 + 2 + HOLD + 2);
        run(100);
        wait_idle();

        // Address collision.
        words[1] = 32'h0000_1235; req = 4'b0010; c0 = cyc;
        push(1'b0, 1, 32'h0000_1235, c0 + 2);
        run(20);
        wait_idle();
        words[2] = 32'hABCD_0005; req = 4'b0100; c0 = cyc;
        push(1'b1, 2, 32'h0000_1235, c0 + 2);
        run(20);
        chk("coll_busy", 32'(busy), 32'd0);
        quiet(5);
        chk("coll_word", clk_word, 32'h0000_1235);

        // Reset mid-HOLD, then reset pointer gives 0 priority over 3.
        words[0] = 32'h7777_0007; req = 4'b0001; c0 = cyc;
        push(1'b0, 0, 32'h7777_0007, c0 + 2);
        run(20);
        quiet(4);
        chk("midhold_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        @(negedge CLK);
        rst = 1'b0;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_ack",  32'(ack),  32'd0);
        chk("abort_word", clk_word, 32'h7777_0007);
        words[0] = 32'h8000_0008; words[3] = 32'h9000_0009;
        req = 4'b1001; c0 = cyc;
        push(1'b0, 0, 32'h8000_0008, c0 + 2);
        push(1'b0, 3, 32'h9000_0009, c0 + 2 + HOLD + 2);
        run(100);
        wait_idle();

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end
endmodule

// File: doc/clk_prog_arbiter.md
# clk_prog_arbiter

Round-robin arbiter that shares the clock-synthesizer MICROWIRE programming engine between up to `N_REQ` requesters (slow-control register bus, link-recovery logic, test sequencer). It sits in the `CLK` domain between the requesters and the engine's 32-bit `clk_word` input. The block presents one word at a time and guarantees spacing between writes. The engine detects a new write by a change in `clk_word[3:0]`, so the block rejects any request that would not produce such a change.

## Interface
Parameters:
- `N_REQ`, 4: number of requesters, 2..8.
- `HOLD_CYCLES`, 450000: `CLK` cycles `clk_word` is held after an update. Must be ≥ one full engine serial write (about 102 divided-clock periods × 4096).
- `CNT_W`, 20: hold-counter width. Must satisfy `HOLD_CYCLES` < 2^`CNT_W`.

Ports:
- `CLK`, in, 1: FPGA clock.
- `rst`, in, 1: synchronous, active-high reset.
- `req`, in, `N_REQ`: level request, one bit per requester. Held until `ack` or `err`.
- `req_word`, in, 32×`N_REQ`: flattened words. Requester k uses bits [32k+31:32k]. Stable while `req[k]` is high.
- `ack`, out, `N_REQ`: one-cycle pulse; the word has been handed to the engine.
- `err`, out, `N_REQ`: one-cycle pulse; the word was rejected because its address nibble equals the current `clk_word[3:0]`.
- `prog_done`, in, 1: engine power-up programming complete (`done`).
- `clk_word`, out, 32: word to the engine.
- `busy`, out, 1: high in GRANT and HOLD.

## Operation
- States: IDLE, GRANT, HOLD.
- IDLE: when `prog_done`=1 and any `req` bit is high, the round-robin selector picks a winner → GRANT. With `prog_done`=0, requests wait and no `ack` or `err` is issued.
- Round robin:
  - Priority starts at index `ptr`+1 (mod `N_REQ`) and ascends with wrap.
  - `ptr` updates to the winner on every `ack` or `err`.
  - Reset value of `ptr` is `N_REQ`-1, so requester 0 has first priority.
- GRANT, one cycle:
  - If `req_word[winner][3:0]` == `clk_word[3:0]`: pulse `err[winner]` → IDLE. `clk_word` is unchanged.
  - Otherwise: load `clk_word` with the winner's word, pulse `ack[winner]`, load the hold counter with `HOLD_CYCLES`-1 → HOLD.
- HOLD:
  - The counter decrements each cycle; at 0 → IDLE.
  - Requests arriving during HOLD are queued only by their `req` level; there is no internal storage.
- If `prog_done` falls (engine re-initialising), any HOLD completes normally. No new grant is made until `prog_done`=1.
- The `req[winner]` level is sampled only in the IDLE cycle. A requester dropping `req` during GRANT is still served.
- Reset:
  - `state`=IDLE; `ack`, `err` = 0; `busy`=0; counter=0; `ptr`=`N_REQ`-1.
  - `clk_word` is NOT reset. A mid-operation reset must not create a spurious nibble change at the engine.
  - Power-on initial value of `clk_word` is 32'hFFFF_FFFF, matching the engine's idle sampling registers.
- A reset during HOLD aborts the hold immediately. The engine completes the write already started.

## Timing
- `req` high in cycle n (IDLE, `prog_done`=1) → GRANT at n+1 → `ack`/`err` and `clk_word` update registered, visible at n+2.
- `busy` is high from n+1 through the last HOLD cycle.
- Back-to-back accepted writes are spaced exactly `HOLD_CYCLES`+2 cycles apart (`clk_word` update to `clk_word` update).
- A rejection costs 2 cycles. The next grant can occur 2 cycles after `err`.
- All outputs are registered. There are no combinational paths from `req` to any output.

## Structure
- Package `clk_prog_pkg` holds:
  - `CLK_WORD_W`=32 and `ADDR_LSB_W`=4.
  - Default `HOLD_CYCLES` and the state enum `{IDLE, GRANT, HOLD}`.
- Sub-module `rr_arbiter` (parameter `N`):
  - Inputs: `req` and `ptr`.
  - Outputs: a one-hot grant and its binary index.
  - Purely combinational, reused by other shared resources.
- Top level holds the FSM, hold counter, `ptr` register and `clk_word` register.

## Test plan
- Gating: `prog_done`=0, `req`=4'b0001 → no `ack` for 1000 cycles. Raise `prog_done` → `ack[0]` two cycles later, `clk_word`=`req_word[0]`.
- Fairness: `req`=4'b1111 with words ending in nibbles 1,2,3,4 (`HOLD_CYCLES`=16 in sim) → grant order 0,1,2,3. Each `ack` is 18 cycles after the previous.
- Wrap-around: last winner 3, `req`=4'b1001 → requester 0 is served before requester 3.
- Address collision: `clk_word`=32'h0000_1235, requester 2 presents 32'hABCD_0005 → `err[2]`, no `ack`, `clk_word` unchanged, `busy` low after 2 cycles.
- Reset mid-HOLD: assert `rst` 5 cycles into HOLD → next cycle IDLE, `busy`=0, `clk_word` retains the last written value, `ptr`=`N_REQ`-1.
- Power-on: `clk_word`=32'hFFFF_FFFF before any grant. The first word with nibble F is rejected with `err`.
